// File: rtl/sfifo_rd_stream_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
// Sizing of the skid buffer and the FIFO read latency it is built around.
package sfifo_rd_stream_pkg;

    localparam int unsigned SKID_ENTRIES = 2;
    localparam int unsigned RD_LATENCY   = 1;
    localparam int unsigned LEVEL_W      = $clog2(SKID_ENTRIES + 1);
    localparam int unsigned OCC_W        = LEVEL_W + 1;

    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [OCC_W-1:0]   occ_t;

    // The issue/capture pipeline below only handles a single-cycle RAM read.
    function automatic bit rd_latency_supported();
        return RD_LATENCY == 1;
    endfunction

    // Buffer fill after one edge; clear dominates write and pop.
    function automatic level_t level_next(
        input level_t cur,
        input logic   inc,
        input logic   dec,
        input logic   clr
    );
        level_t nxt;
        nxt = cur;
        if (clr) begin
            nxt = '0;
        end else begin
            nxt = level_t'(cur + level_t'(inc) - level_t'(dec));
        end
        return nxt;
    endfunction

    // Words buffered plus the word travelling out of the FIFO RAM.
    function automatic occ_t occupancy(input level_t lvl, input logic in_flight);
        return occ_t'({1'b0, lvl}) + occ_t'(in_flight);
    endfunction

endpackage : sfifo_rd_stream_pkg

// File: rtl/sfifo_skid_buf.sv
// Two-entry register buffer absorbing the FIFO read latency.
// Write at tail, read at head; clear empties it without touching stored data.
module sfifo_skid_buf
    import sfifo_rd_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output level_t           level
);

    logic [WIDTH-1:0] mem [SKID_ENTRIES];
    logic             head;
    logic             tail;

    // Full buffer with a write and a pop in one cycle: tail equals head, so the
    // incoming word lands in the slot being vacated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SKID_ENTRIES); i++) begin
                mem[i] <= '0;
            end
            head  <= 1'b0;
            tail  <= 1'b0;
            level <= '0;
        end else begin
            if (wr_en) begin
                mem[tail] <= wr_data;
                tail      <= ~tail;
            end
            if (clear) begin
                head <= tail;
            end else if (pop) begin
                head <= ~head;
            end
            level <= level_next(level, wr_en, pop, clear);
        end
    end

    assign data  = mem[head];
    assign valid = (level != '0);

endmodule : sfifo_skid_buf

// File: rtl/sfifo_rd_stream.sv
// Drains the synchronous FIFO read port onto a valid/ready stream at one word
// per cycle, tracking the word in flight from the FIFO RAM.
module sfifo_rd_stream
    import sfifo_rd_stream_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               FIFOEmpty,
    input  logic [Width-1:0]   RDData,
    output logic               FIFORdReq,
    output logic [Width-1:0]   OutData,
    output logic               OutValid,
    input  logic               OutReady,
    input  logic               Flush,
    output logic [LEVEL_W-1:0] Level
);

    if (!rd_latency_supported()) begin : g_rd_latency_check
        $error("sfifo_rd_stream supports RD_LATENCY == 1 only");
    end

    logic   in_flight;
    logic   pop;
    logic   capture;
    level_t buf_level;
    occ_t   occ;

    assign pop     = OutValid & OutReady;
    assign capture = in_flight & ~Flush;
    assign occ     = occupancy(buf_level, in_flight);

    // Issue only when a slot is guaranteed for the returning word; a same-cycle
    // pop frees one, hence the intended OutReady -> FIFORdReq path.
    assign FIFORdReq = reset & ~FIFOEmpty & ~Flush
                     & ((occ < occ_t'(SKID_ENTRIES)) | pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_flight <= 1'b0;
        end else begin
            in_flight <= FIFORdReq & ~FIFOEmpty;
        end
    end

    sfifo_skid_buf #(
        .WIDTH (Width)
    ) u_skid (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (capture),
        .wr_data (RDData),
        .pop     (pop),
        .clear   (Flush),
        .data    (OutData),
        .valid   (OutValid),
        .level   (buf_level)
    );

    assign Level = buf_level;

endmodule : sfifo_rd_stream

// File: tb/tb_sfifo_rd_stream.sv
// Directed bench for sfifo_rd_stream with a behavioural single-latency FIFO model.
`timescale 1ns/1ps
module tb_sfifo_rd_stream;

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_empty;
    logic [7:0] rd_data;
    logic       rd_req;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       flush;
    logic [1:0] level;

    int errors = 0;
    int checks = 0;
    int issues = 0;
    logic inflight_m = 1'b0;

    logic [7:0] fifo_q[$];
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    sfifo_rd_stream #(.Width(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .FIFOEmpty (fifo_empty),
        .RDData    (rd_data),
        .FIFORdReq (rd_req),
        .OutData   (out_data),
        .OutValid  (out_valid),
        .OutReady  (out_ready),
        .Flush     (flush),
        .Level     (level)
    );

    // One clock: sample handshakes mid-cycle, advance the FIFO model after the edge.
    task automatic tick();
        logic issue;
        @(negedge clk);
        issue = reset && rd_req && !fifo_empty;
        if (issue) issues++;
        if (out_valid && out_ready) rx_q.push_back(out_data);
        @(posedge clk);
        #1;
        if (issue) rd_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        inflight_m = issue;
        checks++;
        assert (int'(level) + int'(inflight_m) <= 2)
        else begin
            errors++;
            $display("FAIL invariant: level=%0d inflight=%0d sum exceeds 2", level, inflight_m);
        end
    endtask

    task automatic load(input int first, input int count);
        for (int i = 0; i < count; i++) fifo_q.push_back(8'(first + i));
        fifo_empty = (fifo_q.size() == 0);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        fifo_empty = 1'b1; rd_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (rd_req !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || level !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle c%0d: req=%b valid=%b data=%h level=%0d, want 0/0/00/0",
                         c, rd_req, out_valid, out_data, level);
            end
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        load(1, 8);
        checks++;
        if (rd_req !== 1'b1) begin
            errors++; $display("FAIL stream_issue: req=%b want 1", rd_req);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_lat1: valid=%b want 0", out_valid);
        end
        tick();
        for (int i = 1; i <= 8; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                errors++;
                $display("FAIL stream_word%0d: valid=%b data=%h want 1/%h", i, out_valid, out_data, 8'(i));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0 || level !== 2'd0) begin
            errors++; $display("FAIL stream_drained: valid=%b level=%0d want 0/0", out_valid, level);
        end
    endtask

    task automatic test_backpressure();
        int budget;
        out_ready = 1'b0;
        rx_q.delete();
        issues = 0;
        load(1, 8);
        repeat (6) tick();
        checks++;
        if (issues != 2 || level !== 2'd2 || out_data !== 8'h01 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: issues=%0d level=%0d data=%h valid=%b want 2/2/01/1",
                     issues, level, out_data, out_valid);
        end
        out_ready = 1'b1;
        budget = 0;
        while ((rx_q.size() < 8 || out_valid) && budget < 40) begin
            tick();
            budget++;
        end
        checks++;
        if (rx_q.size() != 8) begin
            errors++; $display("FAIL bp_count: got %0d words want 8", rx_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < 8; i++) begin
            checks++;
            if (rx_q[i] !== 8'(i + 1)) begin
                errors++; $display("FAIL bp_order%0d: got %h want %h", i, rx_q[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int budget;
        logic [7:0] w;
        rx_q.delete();
        for (int i = 0; i < 256; i++) begin
            w = 8'($urandom_range(0, 255));
            exp_q.push_back(w);
            fifo_q.push_back(w);
        end
        fifo_empty = 1'b0;
        budget = 0;
        while (rx_q.size() < 256 && budget < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            budget++;
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (rx_q.size() != 256 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_count: got %0d words valid=%b want 256/0", rx_q.size(), out_valid);
        end
        for (int i = 0; i < rx_q.size() && i < 256; i++) begin
            checks++;
            if (rx_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_word%0d: got %h want %h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        rx_q.delete();
        fifo_q.push_back(8'hA0);
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'hA2);
        fifo_empty = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        #1;
        checks++;
        if (level !== 2'd1 || inflight_m !== 1'b1 || rd_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_pre: level=%0d inflight=%b req=%b want 1/1/0", level, inflight_m, rd_req);
        end
        tick();
        flush = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || level !== 2'd0 || rd_req !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: valid=%b level=%0d req=%b want 0/0/1", out_valid, level, rd_req);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_lat1: valid=%b want 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA2) begin
            errors++; $display("FAIL flush_next: valid=%b data=%h want 1/a2", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA2 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_delivered: words=%0d first=%h valid=%b want 1/a2/0",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        load(1, 8);
        repeat (4) tick();
        checks++;
        if (level !== 2'd2) begin
            errors++; $display("FAIL rst_pre: level=%0d want 2", level);
        end
        #2 reset = 1'b0;
        fifo_q.delete();
        fifo_empty = 1'b1;
        rd_data = 8'h00;
        inflight_m = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || level !== 2'd0 || rd_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: valid=%b data=%h level=%0d req=%b want 0/00/0/0",
                     out_valid, out_data, level, rd_req);
        end
        repeat (2) tick();
        reset = 1'b1;
        out_ready = 1'b1;
        load(8'h11, 3);
        checks++;
        if (rd_req !== 1'b1) begin
            errors++; $display("FAIL rst_reissue: req=%b want 1", rd_req);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_lat1: valid=%b want 0", out_valid);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(8'h11 + i)) begin
                errors++;
                $display("FAIL rst_word%0d: valid=%b data=%h want 1/%h", i, out_valid, out_data, 8'(8'h11 + i));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_drained: valid=%b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_flush();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sfifo_rd_stream

// File: doc/sfifo_rd_stream.md
# sfifo_rd_stream

Read-side drain adapter for the synchronous FIFO. It pops words from the FIFO's request/empty read port and presents them on a valid/ready stream. It absorbs the one-cycle RAM read latency with a 2-entry output buffer, so a consumer that holds OutReady high receives one word per cycle. It sits between the FIFO read port and any downstream stream consumer, in the same clock domain.

## Interface
- Width, 8, data word width; must equal the FIFO's Width.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- FIFOEmpty  input  1  FIFO empty flag.
- RDData  input  Width  FIFO read data. Valid the cycle after a FIFORdReq accepted while FIFOEmpty=0.
- FIFORdReq  output  1  pop request to the FIFO.
- OutData  output  Width  stream data.
- OutValid  output  1  OutData holds a word.
- OutReady  input  1  consumer accepts the word this cycle.
- Flush  input  1  synchronous discard of buffered and in-flight words.
- Level  output  2  buffered word count, 0..2.

## Operation
- Read contract with the FIFO:
  - FIFORdReq=1 with FIFOEmpty=0 in cycle N pops one word.
  - That word is on RDData throughout cycle N+1 and is captured at the end of N+1.
  - FIFORdReq with FIFOEmpty=1 is ignored.
- State registers:
  - 2-entry buffer with 1-bit head and tail pointers.
  - Level, 0..2.
  - InFlight, 1 bit: a pop was issued last cycle.
- Pop and capture:
  - Pop = OutValid & OutReady.
  - Capture = InFlight & ~Flush. Writes RDData at tail; tail toggles.
- Issue (combinational): FIFORdReq = ~FIFOEmpty & ~Flush & ((Level + InFlight) < 2 | Pop).
  - This creates a combinational path from OutReady to FIFORdReq. The path is intended.
- Next state:
  - InFlight <= FIFORdReq & ~FIFOEmpty.
  - Level <= Level + Capture − Pop.
  - Invariant: Level + InFlight ≤ 2 at every edge. Overflow cannot occur by construction; the bench checks it with an assertion.
- Output:
  - OutValid = (Level != 0).
  - OutData = buffer[head].
  - Head toggles on Pop.
  - OutData is stable while OutValid=1 and OutReady=0.
- Simultaneous capture and pop at Level=2: Level stays 2, and the write goes to the slot just freed.
- Flush cycle:
  - FIFORdReq=0.
  - Pop is still honored if OutReady=1.
  - At the edge: Level <= 0, head <= tail, InFlight <= 0, and the in-flight word (if any) is dropped.
  - Cycle after Flush: OutValid=0.
- Reset (asynchronous, any time, including mid-transfer):
  - Level=0, InFlight=0, head=tail=0, buffer cleared to 0.
  - Outputs: OutValid=0, OutData=0, Level=0, FIFORdReq=0. FIFORdReq is low because it is gated while reset is low.
  - A word popped from the FIFO just before reset is lost. The FIFO is reset by the same signal.

## Timing
- Empty-to-valid latency: FIFOEmpty falls in cycle 0 → FIFORdReq=1 in cycle 0 → capture at the end of cycle 1 → OutValid=1 in cycle 2.
- Throughput: with OutReady held high and FIFO non-empty, one word per cycle sustained with no bubbles. Steady state is Level=1, InFlight=1.
- Backpressure: with OutReady=0, at most 2 words are popped beyond the last accepted one. FIFORdReq then stays low until a Pop occurs.
- Pop takes effect at the edge; Level reflects it the next cycle.

## Structure
- Shared package holds:
  - SkidEntries = 2.
  - RdLatency = 1.
  - Level width = $clog2(SkidEntries+1).
- The implementation targets RdLatency=1 only. A package check errors if RdLatency != 1.
- Sub-module: sfifo_skid_buf.
  - 2-entry register buffer with write, pop and clear inputs.
  - Outputs: data, valid and level.
- The top level keeps InFlight and the issue logic.

## Test plan
- Reset release with FIFO empty, 10 cycles → FIFORdReq=0, OutValid=0, OutData=0, Level=0 throughout.
- Load FIFO with 0x01..0x08, OutReady=1 → OutValid rises 2 cycles after FIFOEmpty falls. 0x01..0x08 arrive on 8 consecutive cycles, then OutValid=0.
- Same load, OutReady=0 for 6 cycles, then 1:
  - Exactly 2 FIFORdReq pulses while stalled; Level=2; OutData holds 0x01.
  - After release, all 8 words arrive in order with no loss or duplication.
- Random OutReady (50%) with 256 random words → output sequence equals input sequence; Level + InFlight ≤ 2 at every edge.
- Flush asserted the cycle after a FIFORdReq, with Level=1:
  - The next cycle shows OutValid=0 and Level=0.
  - The in-flight word is not delivered.
  - The following FIFO word appears next, 2 cycles after issue.
- Reset asserted mid-stream at Level=2 → outputs reach their reset values immediately. After release with a refilled FIFO, normal 2-cycle latency resumes.
